// File: rtl/pattern_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pattern_scan_ctrl_pkg
// Shared definitions for the pattern scan controller and its sequence detector:
//   - DEFAULT_WIDTH            : default scanned word width
//   - DET_S0..DET_S3           : detector state encodings (Gray-like walk)
//   - CTRL_IDLE/SHIFT/DONE     : controller state encodings
//   - det_next_state()         : detector transition function
// -----------------------------------------------------------------------------
package pattern_scan_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Detector states. S2 is 11 so each step of the 0-driven walk
    // S0->S1->S2->S3->S0 flips exactly one state bit.
    localparam logic [1:0] DET_S0 = 2'b00;
    localparam logic [1:0] DET_S1 = 2'b01;
    localparam logic [1:0] DET_S2 = 2'b11;
    localparam logic [1:0] DET_S3 = 2'b10;

    // Controller states.
    localparam logic [1:0] CTRL_IDLE  = 2'b00;
    localparam logic [1:0] CTRL_SHIFT = 2'b01;
    localparam logic [1:0] CTRL_DONE  = 2'b10;

    // Detector transition for input bit a; any unknown code recovers to S0.
    function automatic logic [1:0] det_next_state(input logic [1:0] state,
                                                  input logic       a);
        logic [1:0] nxt;
        case (state)
            DET_S0:  nxt = a ? DET_S0 : DET_S1;
            DET_S1:  nxt = a ? DET_S1 : DET_S2;
            DET_S2:  nxt = a ? DET_S0 : DET_S3;
            DET_S3:  nxt = a ? DET_S2 : DET_S0;
            default: nxt = DET_S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pattern_scan_ctrl_seq_detect_core.sv
// -----------------------------------------------------------------------------
// seq_detect_core
// 4-state Mealy sequence detector, enable-gated, with synchronous clear.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset (state -> S0)
//   clear  : synchronous clear to S0, takes priority over enable
//   enable : advance the state machine this cycle
//   a      : serial input bit
//   y      : combinational hit, a & (state == S1)
// -----------------------------------------------------------------------------
module seq_detect_core
    import pattern_scan_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic a,
    output logic y
);

    logic [1:0] state_r;

    // Detector state register: reset, then clear, then enabled advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= DET_S0;
        end else if (clear) begin
            state_r <= DET_S0;
        end else if (enable) begin
            state_r <= det_next_state(state_r, a);
        end else begin
            state_r <= state_r;
        end
    end

    // Mealy hit output; the controller only counts it while enabled.
    always_comb begin
        y = 1'b0;
        if (a && (state_r == DET_S1)) begin
            y = 1'b1;
        end else begin
            y = 1'b0;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_scan_ctrl
// Accepts a WIDTH-bit word, clears the shared detector, feeds the word MSB
// first one bit per cycle and returns the number of detector hits.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   in_valid/in_ready     : word handshake (ready only in IDLE)
//   in_data               : word, bit WIDTH-1 scanned first
//   out_valid/out_ready   : result handshake, result held until accepted
//   out_count, out_any    : hit count and (hit count != 0)
//   out_first             : scan index of first hit (only with macro
//                           PATTERN_SCAN_FIRST_HIT_EN defined)
//   busy                  : high in SHIFT and DONE
// -----------------------------------------------------------------------------
module pattern_scan_ctrl
    import pattern_scan_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
)
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           out_count,
    output logic                       out_any,
`ifdef PATTERN_SCAN_FIRST_HIT_EN
    output logic [$clog2(WIDTH)-1:0]   out_first,
`endif
    output logic                       busy
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] shreg_r;
    logic [IDX_W-1:0] idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic             any_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic             accept_s;
    logic             shift_s;
    logic             last_s;
    logic             det_y_s;
    logic             hit_s;

    seq_detect_core u_det (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept_s),
        .enable (shift_s),
        .a      (shreg_r[WIDTH-1]),
        .y      (det_y_s)
    );

    // Handshake / scan qualifiers derived from the current state.
    always_comb begin
        accept_s = (state_r == CTRL_IDLE) && in_valid;
        shift_s  = (state_r == CTRL_SHIFT);
        last_s   = shift_s && (idx_r == IDX_W'(WIDTH - 1));
        hit_s    = shift_s && det_y_s;
    end

    // Controller next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            CTRL_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = CTRL_SHIFT;
                end else begin
                    state_nxt_s = CTRL_IDLE;
                end
            end
            CTRL_SHIFT: begin
                if (last_s) begin
                    state_nxt_s = CTRL_DONE;
                end else begin
                    state_nxt_s = CTRL_SHIFT;
                end
            end
            CTRL_DONE: begin
                if (out_ready) begin
                    state_nxt_s = CTRL_IDLE;
                end else begin
                    state_nxt_s = CTRL_DONE;
                end
            end
            default: state_nxt_s = CTRL_IDLE;
        endcase
    end

    // State, registered handshake flags, shift register, index and hit count.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= CTRL_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            shreg_r     <= '0;
            idx_r       <= '0;
            cnt_r       <= '0;
            any_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            // Flags are registered from the next state so they line up with it.
            in_ready_r  <= (state_nxt_s == CTRL_IDLE);
            out_valid_r <= (state_nxt_s == CTRL_DONE);
            busy_r      <= (state_nxt_s != CTRL_IDLE);
            if (accept_s) begin
                shreg_r <= in_data;
                idx_r   <= '0;
                cnt_r   <= '0;
                any_r   <= 1'b0;
            end else if (shift_s) begin
                shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                idx_r   <= idx_r + IDX_W'(1);
                if (hit_s) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    any_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r;
                    any_r <= any_r;
                end
            end else begin
                shreg_r <= shreg_r;
                idx_r   <= idx_r;
                cnt_r   <= cnt_r;
                any_r   <= any_r;
            end
        end
    end

`ifdef PATTERN_SCAN_FIRST_HIT_EN
    logic [IDX_W-1:0] first_r;

    // Latch the scan index of the first hit; any_r still low means none yet.
    always_ff @(posedge clock) begin
        if (reset) begin
            first_r <= '0;
        end else if (accept_s) begin
            first_r <= '0;
        end else if (hit_s && !any_r) begin
            first_r <= idx_r;
        end else begin
            first_r <= first_r;
        end
    end

    // First-hit output driver.
    always_comb begin
        out_first = first_r;
    end
`endif

    // Output drivers; all come straight from registers.
    always_comb begin
        in_ready  = in_ready_r;
        out_valid = out_valid_r;
        busy      = busy_r;
        out_count = cnt_r;
        out_any   = any_r;
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pattern_scan_ctrl
// Directed bench for pattern_scan_ctrl. A word-level model predicts the
// handshake phase and result of every accepted word; a negedge process
// compares the DUT against it, and the directed sequence adds literal checks.
// Honors PATTERN_SCAN_FIRST_HIT_EN for the optional out_first port.
// -----------------------------------------------------------------------------
module tb_pattern_scan_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = $clog2(WIDTH);

    logic             clock     = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data   = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] out_count;
    logic             out_any;
    logic             busy;
`ifdef PATTERN_SCAN_FIRST_HIT_EN
    logic [IDX_W-1:0] out_first;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    always #5 clock = ~clock;

    pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_any   (out_any),
`ifdef PATTERN_SCAN_FIRST_HIT_EN
        .out_first (out_first),
`endif
        .busy      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Word-level model: walk the detector's transition table over the bits
    // in scan order. Returns the hit count, or the first hit index if asked.
    function automatic int model_scan(input logic [WIDTH-1:0] w, input bit want_first);
        int nxt0[4] = '{1, 2, 3, 0};
        int nxt1[4] = '{0, 1, 0, 2};
        int s     = 0;
        int hits  = 0;
        int first = -1;
        bit a;
        for (int i = 0; i < WIDTH; i++) begin
            a = w[WIDTH-1-i];
            if (a && s == 1) begin
                hits++;
                if (first < 0) first = i;
            end
            s = a ? nxt1[s] : nxt0[s];
        end
        if (want_first) return (first < 0) ? 0 : first;
        return hits;
    endfunction

    // Model phase: 0 idle, 1 scanning (m_left cycles to go), 2 result held.
    int m_phase = 0;
    int m_left  = 0;
    int m_count = 0;
    int m_first = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_left  <= WIDTH;
                    m_count <= model_scan(in_data, 1'b0);
                    m_first <= model_scan(in_data, 1'b1);
                end
                1: if (m_left == 1) m_phase <= 2; else m_left <= m_left - 1;
                2: if (out_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("in_ready",  int'(in_ready),  int'(m_phase == 0));
            check("out_valid", int'(out_valid), int'(m_phase == 2));
            check("busy",      int'(busy),      int'(m_phase != 0));
            if (m_phase == 2) begin
                check("out_count", int'(out_count), m_count);
                check("out_any",   int'(out_any),   int'(m_count != 0));
`ifdef PATTERN_SCAN_FIRST_HIT_EN
                check("out_first", int'(out_first), m_first);
`endif
            end
        end
    end

    // Present a word in IDLE; returns #1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] data);
        @(posedge clock); #1;
        check("send_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = data;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Wait (bounded) for out_valid, check latency and literal results.
    task automatic wait_done(input int exp_cnt, input int exp_any, input int exp_first);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 4 * WIDTH) begin
            @(posedge clock); #1;
            n++;
            if (out_valid) seen = 1'b1;
        end
        check("latency", n, WIDTH);
        check("lit_count", int'(out_count), exp_cnt);
        check("lit_any",   int'(out_any),   exp_any);
`ifdef PATTERN_SCAN_FIRST_HIT_EN
        check("lit_first", int'(out_first), exp_first);
`else
        if (exp_first < 0) $display("bad exp_first %0d", exp_first);
`endif
    endtask

    task automatic run_word(input logic [WIDTH-1:0] data, input int c, input int a, input int f);
        send(data);
        wait_done(c, a, f);
    endtask

    initial begin
        // 1. Reset for two cycles with in_valid high: must not be accepted.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk_en   = 1'b1;
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy",      int'(busy),      0);
        check("rst_count",     int'(out_count), 0);
        check("rst_any",       int'(out_any),   0);
        @(posedge clock); #1;
        check("idle_in_ready", int'(in_ready), 1);

        // 2-4. Back-to-back words with out_ready held high.
        out_ready = 1'b1;
        run_word(8'b0110_0110, 2, 1, 1);
        run_word(8'hFF, 0, 0, 0);
        run_word(8'h7F, 7, 1, 1);
        run_word(8'h00, 0, 0, 0);

        // 5. Hold the result for 5 cycles with a competing word pending.
        @(posedge clock); #1;
        out_ready = 1'b0;
        send(8'h7F);
        wait_done(7, 1, 1);
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("hold_valid", int'(out_valid), 1);
            check("hold_count", int'(out_count), 7);
            check("hold_ready", int'(in_ready),  0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("rel_ready", int'(in_ready),  1);
        check("rel_valid", int'(out_valid), 0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("acc2_busy", int'(busy), 1);
        wait_done(0, 0, 0);

        // 6. Reset on the third SHIFT cycle discards the word.
        send(8'h7F);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_in_ready",  int'(in_ready),  1);
        check("mid_out_valid", int'(out_valid), 0);
        check("mid_busy",      int'(busy),      0);
        check("mid_count",     int'(out_count), 0);
        run_word(8'b0110_0110, 2, 1, 1);

        @(posedge clock); #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
